load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port req_valid, input, 1 bit: pipeline access request present.
REQ-004 SHALL have port req_ready, output, 1 bit: unit can accept a request.
REQ-005 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port req_size, input, 2 bits: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 SHALL have port req_unsigned, input, 1 bit: 1 = zero-extend loads, 0 = sign-extend.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 SHALL have port resp_valid, output, 1 bit: response available.
REQ-011 SHALL have port resp_ready, input, 1 bit: consumer accepts the response.
REQ-012 SHALL have port resp_rdata, output, 32 bits: extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_error, output, 1 bit: request rejected, no memory access made.
REQ-014 SHALL have port mem_read_address, output, 32 bits: word index to data memory.
REQ-015 SHALL have port mem_write_address, output, 32 bits: word index to data memory.
REQ-016 SHALL have port mem_write_data, output, 32 bits: full word to write.
REQ-017 SHALL have port sig_mem_read, output, 1 bit: memory read enable.
REQ-018 SHALL have port sig_mem_write, output, 1 bit: memory write enable; memory writes on the clk edge while it is high.
REQ-019 SHALL have port mem_read_data, input, 32 bits: combinational word from data memory.

Function
REQ-020 SHALL implement states IDLE, READ, WRITE, RESP.
REQ-021 SHALL drive req_ready=1 only in IDLE with rst low.
REQ-022 SHALL accept a request on the clk edge where req_valid and req_ready are both 1, and latch all req_* fields at that edge.
REQ-023 SHALL flag an error on any of these conditions, checked at acceptance:
- req_size=11
- halfword with addr[0]=1
- word with addr[1:0]!=00
- addr>=1024 (memory is 256 words)
REQ-024 SHALL, on an error, go IDLE->RESP with resp_error=1, resp_rdata=0, and no memory enable asserted.
REQ-025 SHALL compute the word index as {24'b0, addr[9:2]} and drive it on both mem_read_address and mem_write_address from acceptance until return to IDLE.
REQ-026 SHALL handle a load as IDLE->READ->RESP:
- READ asserts sig_mem_read for exactly one cycle.
- mem_read_data is captured at the end of READ.
REQ-027 SHALL handle a word store as IDLE->WRITE->RESP:
- WRITE asserts sig_mem_write for exactly one cycle.
- mem_write_data equals req_wdata.
REQ-028 SHALL handle a byte/halfword store as read-modify-write, IDLE->READ->WRITE->RESP:
- Only the addressed lanes are replaced with req_wdata.
- All other lanes keep the captured word.
REQ-029 SHALL use little-endian lanes: byte k = bits [8k+7:8k] for k=addr[1:0]; halfword at addr[1]=1 occupies [31:16].
REQ-030 SHALL extract loads by lane and extend per req_unsigned; word loads are returned unmodified.
REQ-031 SHALL meet these latencies from the acceptance edge T:
- error: resp_valid at T+1
- load and word store: resp_valid at T+2
- sub-word store: resp_valid at T+3
REQ-032 SHALL hold resp_valid, resp_rdata and resp_error stable in RESP until resp_ready=1, then return to IDLE on that edge.
REQ-033 SHALL never assert sig_mem_read and sig_mem_write in the same cycle.
REQ-034 SHALL hold sig_mem_read=0 and sig_mem_write=0 in IDLE and RESP.
REQ-035 SHALL ignore req_valid outside IDLE; requests are not queued.

Reset
REQ-036 SHALL, while rst is high, immediately force:
- state to IDLE
- req_ready, resp_valid, resp_error, sig_mem_read, sig_mem_write to 0
- resp_rdata, mem_read_address, mem_write_address, mem_write_data to 0
REQ-037 SHALL abort any in-flight access on reset: no write occurs if rst rises during WRITE, and no response is produced for the aborted request.
REQ-038 SHALL leave IDLE with req_ready=1 on the first clk edge after rst falls.

Verification
REQ-039 Word load: mem word 3 = 0x8000_00F0; load size=10, addr=0x0C -> sig_mem_read one cycle, mem_read_address=3, resp_rdata=0x8000_00F0 at T+2.
REQ-040 Byte load sign/zero: mem word 0 = 0x1122_83FF; load byte addr=0x01 -> 0xFFFF_FF83 signed; with req_unsigned=1 -> 0x0000_0083.
REQ-041 Sub-word store: mem word 2 = 0xAABB_CCDD; store half addr=0x0A, wdata=0x1234 -> read then write 0x1234_CCDD to index 2, resp_valid at T+3.
REQ-042 Errors: word addr=0x06, half addr=0x03, size=11, addr=0x400 -> each gives resp_error=1 at T+1 with both memory enables 0 throughout.
REQ-043 Backpressure: resp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready=0, new req_valid ignored; resp_ready=1 -> IDLE on the next edge.
REQ-044 Reset mid-store: rst pulsed while in WRITE -> sig_mem_write drops without a clk edge, memory unchanged, no response, req_ready=1 after release.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between the pipeline and a 256-word data memory: aligned
// byte/halfword/word accesses, sub-word stores as read-modify-write.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_read_address,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic        sig_mem_read,
  output logic        sig_mem_write,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  state_t      state, state_next;
  logic [7:0]  index_q;
  logic [1:0]  size_q;
  logic [1:0]  offset_q;
  logic        write_q;
  logic        unsigned_q;
  logic        error_q;
  logic [31:0] rdata_q;
  logic [31:0] wword_q;
  logic        accept;
  logic        req_error;

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: return uns ? {24'b0, b} : {{24{b[7]}}, b};
      SIZE_HALF: return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default:   return word;
    endcase
  endfunction

  // Replaces only the addressed lanes of the captured word with store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off);
    logic [31:0] m;
    m = word;
    case (size)
      SIZE_BYTE: m[{off, 3'b000} +: 8] = wdata[7:0];
      SIZE_HALF: begin
        if (off[1]) m[31:16] = wdata[15:0];
        else        m[15:0]  = wdata[15:0];
      end
      default:   m = wdata;
    endcase
    return m;
  endfunction

  assign accept = req_valid && req_ready;

  always_comb begin
    req_error = (req_size == 2'b11)
             || (req_size == SIZE_HALF && req_addr[0])
             || (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)
             || (|req_addr[31:10]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_error)                     state_next = RESP;
          else if (!req_write)               state_next = READ;
          else if (req_size == SIZE_WORD)    state_next = WRITE;
          else                               state_next = READ;
        end
      end
      READ:    state_next = write_q ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = resp_ready ? IDLE : RESP;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state == IDLE) && !rst;
    sig_mem_read  = (state == READ);
    sig_mem_write = (state == WRITE);
    resp_valid    = (state == RESP);
    resp_error    = (state == RESP) && error_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_q    <= '0;
      size_q     <= '0;
      offset_q   <= '0;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      error_q    <= 1'b0;
      rdata_q    <= '0;
      wword_q    <= '0;
    end else begin
      if (accept) begin
        index_q    <= req_addr[9:2];
        size_q     <= req_size;
        offset_q   <= req_addr[1:0];
        write_q    <= req_write;
        unsigned_q <= req_unsigned;
        error_q    <= req_error;
        rdata_q    <= '0;
        wword_q    <= req_wdata;
      end else if (state == READ) begin
        // A store passing through READ is a sub-word read-modify-write.
        if (write_q) wword_q <= store_merge(mem_read_data, wword_q, size_q, offset_q);
        else         rdata_q <= load_extend(mem_read_data, size_q, offset_q, unsigned_q);
      end
    end
  end

  assign resp_rdata        = rdata_q;
  assign mem_read_address  = {24'b0, index_q};
  assign mem_write_address = {24'b0, index_q};
  assign mem_write_data    = wword_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 256-word data memory.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_read_address;
  logic [31:0] mem_write_address;
  logic [31:0] mem_write_data;
  logic        sig_mem_read;
  logic        sig_mem_write;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:255];
  int          n_cmp = 0;
  int          n_err = 0;
  int          both_cnt = 0;

  load_store_unit dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_size          (req_size),
    .req_unsigned      (req_unsigned),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_rdata        (resp_rdata),
    .resp_error        (resp_error),
    .mem_read_address  (mem_read_address),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .sig_mem_read      (sig_mem_read),
    .sig_mem_write     (sig_mem_write),
    .mem_read_data     (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_read_address[7:0]];

  always @(posedge clk) begin
    if (sig_mem_write) mem[mem_write_address[7:0]] <= mem_write_data;
  end

  always @(negedge clk) begin
    if (sig_mem_read && sig_mem_write) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for exactly one accepting edge; returns 1ns after it.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    step();
    req_valid    = 1'b0;
  endtask

  logic [1:0]  err_size [4];
  logic [31:0] err_addr [4];

  initial begin
    err_size = '{2'b10, 2'b01, 2'b11, 2'b10};
    err_addr = '{32'h6, 32'h3, 32'h0, 32'h400};
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h1122_83FF;
    mem[2] = 32'hAABB_CCDD;
    mem[3] = 32'h8000_00F0;
    mem[5] = 32'h5566_7788;
    mem[6] = 32'h0BAD_F00D;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;

    #2;
    check("rst_req_ready",   {31'b0, req_ready},     32'd0);
    check("rst_resp_valid",  {31'b0, resp_valid},    32'd0);
    check("rst_mem_rd",      {31'b0, sig_mem_read},  32'd0);
    check("rst_mem_wr",      {31'b0, sig_mem_write}, 32'd0);
    check("rst_rd_addr",     mem_read_address,       32'd0);
    check("rst_wdata",       mem_write_data,         32'd0);
    step();
    rst = 1'b0;
    #1;
    check("post_rst_ready",  {31'b0, req_ready},     32'd1);

    // Word load from index 3.
    issue(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
    check("wl_mem_rd",       {31'b0, sig_mem_read},  32'd1);
    check("wl_mem_wr",       {31'b0, sig_mem_write}, 32'd0);
    check("wl_rd_addr",      mem_read_address,       32'd3);
    check("wl_ready_busy",   {31'b0, req_ready},     32'd0);
    check("wl_no_resp_yet",  {31'b0, resp_valid},    32'd0);
    step();
    check("wl_resp_valid",   {31'b0, resp_valid},    32'd1);
    check("wl_rdata",        resp_rdata,             32'h8000_00F0);
    check("wl_error",        {31'b0, resp_error},    32'd0);
    check("wl_rd_dropped",   {31'b0, sig_mem_read},  32'd0);
    step();
    check("wl_back_idle",    {31'b0, req_ready},     32'd1);

    // Byte loads at addr 1 of 0x112283FF, signed then unsigned.
    issue(1'b0, 2'b00, 1'b0, 32'h1, 32'h0);
    check("bl_rd_addr",      mem_read_address,       32'd0);
    step();
    check("bl_signed",       resp_rdata,             32'hFFFF_FF83);
    step();
    issue(1'b0, 2'b00, 1'b1, 32'h1, 32'h0);
    step();
    check("bl_unsigned",     resp_rdata,             32'h0000_0083);
    step();

    // Halfword loads from word 0: lower half signed, upper half signed.
    issue(1'b0, 2'b01, 1'b0, 32'h0, 32'h0);
    step();
    check("hl_low_signed",   resp_rdata,             32'hFFFF_83FF);
    step();
    issue(1'b0, 2'b01, 1'b0, 32'h2, 32'h0);
    step();
    check("hl_high_signed",  resp_rdata,             32'h0000_1122);
    step();

    // Halfword store at 0x0A: read-modify-write of index 2.
    issue(1'b1, 2'b01, 1'b0, 32'h0A, 32'h0000_1234);
    check("hs_mem_rd",       {31'b0, sig_mem_read},  32'd1);
    check("hs_mem_wr0",      {31'b0, sig_mem_write}, 32'd0);
    check("hs_rd_addr",      mem_read_address,       32'd2);
    step();
    check("hs_mem_wr",       {31'b0, sig_mem_write}, 32'd1);
    check("hs_mem_rd_off",   {31'b0, sig_mem_read},  32'd0);
    check("hs_wr_addr",      mem_write_address,      32'd2);
    check("hs_wr_data",      mem_write_data,         32'h1234_CCDD);
    check("hs_no_resp_yet",  {31'b0, resp_valid},    32'd0);
    step();
    check("hs_resp_valid",   {31'b0, resp_valid},    32'd1);
    check("hs_rdata_zero",   resp_rdata,             32'd0);
    check("hs_mem_word",     mem[2],                 32'h1234_CCDD);
    step();

    // Byte store into lane 3 of word 0.
    issue(1'b1, 2'b00, 1'b0, 32'h3, 32'hFFFF_FFA5);
    step();
    step();
    check("bs_resp_valid",   {31'b0, resp_valid},    32'd1);
    check("bs_mem_word",     mem[0],                 32'hA522_83FF);
    step();

    // Word store: single write cycle, no read.
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    check("ws_mem_wr",       {31'b0, sig_mem_write}, 32'd1);
    check("ws_mem_rd",       {31'b0, sig_mem_read},  32'd0);
    check("ws_wr_addr",      mem_write_address,      32'd4);
    check("ws_wr_data",      mem_write_data,         32'hDEAD_BEEF);
    step();
    check("ws_resp_valid",   {31'b0, resp_valid},    32'd1);
    check("ws_mem_word",     mem[4],                 32'hDEAD_BEEF);
    step();

    // Rejected requests: misaligned word, misaligned half, illegal size, out of range.
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, err_size[i], 1'b0, err_addr[i], 32'h0);
      check($sformatf("err%0d_valid", i), {31'b0, resp_valid},    32'd1);
      check($sformatf("err%0d_flag", i),  {31'b0, resp_error},    32'd1);
      check($sformatf("err%0d_rdata", i), resp_rdata,             32'd0);
      check($sformatf("err%0d_rd", i),    {31'b0, sig_mem_read},  32'd0);
      check($sformatf("err%0d_wr", i),    {31'b0, sig_mem_write}, 32'd0);
      step();
      check($sformatf("err%0d_idle", i),  {31'b0, req_ready},     32'd1);
    end

    // Backpressure: response held for 5 cycles while new requests are offered.
    resp_ready = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
    step();
    req_write = 1'b1; req_size = 2'b10; req_addr = 32'h14; req_wdata = 32'hCAFE_F00D;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_valid", i), {31'b0, resp_valid},    32'd1);
      check($sformatf("bp%0d_rdata", i), resp_rdata,             32'h8000_00F0);
      check($sformatf("bp%0d_ready", i), {31'b0, req_ready},     32'd0);
      check($sformatf("bp%0d_wr", i),    {31'b0, sig_mem_write}, 32'd0);
      req_valid = 1'b1;
      step();
    end
    check("bp_still_valid",  {31'b0, resp_valid},    32'd1);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    step();
    check("bp_released",     {31'b0, req_ready},     32'd1);
    check("bp_resp_gone",    {31'b0, resp_valid},    32'd0);
    check("bp_ignored_req",  mem[5],                 32'h5566_7788);

    // Reset asserted mid-store: write is aborted asynchronously.
    issue(1'b1, 2'b10, 1'b0, 32'h18, 32'h1111_1111);
    check("rs_in_write",     {31'b0, sig_mem_write}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rs_wr_dropped",   {31'b0, sig_mem_write}, 32'd0);
    check("rs_ready_low",    {31'b0, req_ready},     32'd0);
    check("rs_wdata_zero",   mem_write_data,         32'd0);
    step();
    check("rs_mem_intact",   mem[6],                 32'h0BAD_F00D);
    rst = 1'b0;
    #1;
    check("rs_ready_after",  {31'b0, req_ready},     32'd1);
    step();
    check("rs_no_resp",      {31'b0, resp_valid},    32'd0);
    check("rs_mem_final",    mem[6],                 32'h0BAD_F00D);

    check("rd_wr_exclusive", both_cnt,               32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
